// File: rtl/egd_la_stream_bridge.sv
// egd_la_stream_bridge: toggle-handshake LA push channel buffered into a FIFO feeding the decoder bitstream input
// Host events are synchronised, acked by toggle, and popped over valid/ready with first-word-fall-through.
module egd_la_stream_bridge #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic              wb_clk_i,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_tog,
    input  logic              host_oenb,
    input  logic              flush,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              host_ack_tog,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty,
    output logic              ovf_sticky
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PONE = PW'(1);
    localparam logic [LVL_W-1:0] LONE = LVL_W'(1);
    localparam logic [LVL_W-1:0] LFULL = LVL_W'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   tog_q;
    logic [PW-1:0]          wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0]       lvl_q, lvl_d;
    logic                   ack_q, ack_d, ovf_q, ovf_d;
    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic                   ev, pop, push, ovf;

    assign empty        = lvl_q == '0;
    assign full         = lvl_q == LFULL;
    assign level        = lvl_q;
    assign out_valid    = !empty;
    assign out_data     = empty ? '0 : mem_q[rd_q];
    assign host_ack_tog = ack_q;
    assign ovf_sticky   = ovf_q;

    // tog_q tracks the synchronised level even while disabled, so re-enabling never fires a stale event
    assign ev   = (sync_q[SYNC_STAGES-1] ^ tog_q) & !host_oenb;
    assign pop  = out_valid & out_ready;
    assign push = ev & (!full | pop) & !flush;
    assign ovf  = ev & full & !pop & !flush;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], host_tog};
        wr_d   = flush ? '0 : push ? wr_q + PONE : wr_q;
        rd_d   = flush ? '0 : pop ? rd_q + PONE : rd_q;
        lvl_d  = flush ? '0 : (push && !pop) ? lvl_q + LONE : (pop && !push) ? lvl_q - LONE : lvl_q;
        ack_d  = ack_q ^ ev;
        ovf_d  = ovf ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            tog_q  <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            lvl_q  <= '0;
            ack_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            tog_q  <= sync_q[SYNC_STAGES-1];
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            lvl_q  <= lvl_d;
            ack_q  <= ack_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty
    always_ff @(posedge wb_clk_i)
        if (push) mem_q[wr_q] <= host_data;
endmodule
